// File: rtl/sprite_layer_mixer.sv
// Fixed-priority sprite compositor with frame-shadowed enables/background and a 2-stage VGA output pipe.
// Optional per-frame collision report enabled by SPRITE_LAYER_MIXER_COLLISION_EN.
module sprite_layer_mixer #(
    parameter int unsigned LAYERS    = 4,
    parameter int unsigned COLR_BITS = 8,
    parameter logic [3*COLR_BITS-1:0] BG_RESET = 24'h6BE9F2,
    parameter bit H_POL = 1'b1,
    parameter bit V_POL = 1'b1
) (
    input  logic                            i_clk_pix,
    input  logic                            i_rst_n,
    input  logic                            i_frame,
    input  logic                            i_de,
    input  logic                            i_hsync,
    input  logic                            i_vsync,
    input  logic [LAYERS-1:0]               i_drawing,
    input  logic [LAYERS-1:0]               i_trans,
    input  logic [LAYERS*3*COLR_BITS-1:0]   i_rgb,
    input  logic [LAYERS-1:0]               i_layer_en,
    input  logic [3*COLR_BITS-1:0]          i_bg_colr,
`ifdef SPRITE_LAYER_MIXER_COLLISION_EN
    output logic [LAYERS-1:0]               o_collide,
    output logic                            o_collide_stb,
`endif
    output logic                            vga_hsync,
    output logic                            vga_vsync,
    output logic                            vga_blank_n,
    output logic                            vga_sync_n,
    output logic [COLR_BITS-1:0]            vga_r,
    output logic [COLR_BITS-1:0]            vga_g,
    output logic [COLR_BITS-1:0]            vga_b
);

    localparam int unsigned CW = 3 * COLR_BITS;

    logic [LAYERS-1:0] en_sh_q, en_sh_d;
    logic [CW-1:0]     bg_sh_q, bg_sh_d;
    logic [LAYERS-1:0] en_eff;
    logic [CW-1:0]     bg_eff;
    logic [LAYERS-1:0] vis;
    logic [CW-1:0]     colr_s1_q, colr_s1_d;
    logic              de_s1_q, hs_s1_q, vs_s1_q;

    // The frame-start pixel must already see the new shadow values, hence the bypass.
    always_comb begin
        en_sh_d = i_frame ? i_layer_en : en_sh_q;
        bg_sh_d = i_frame ? i_bg_colr  : bg_sh_q;
        en_eff  = en_sh_d;
        bg_eff  = bg_sh_d;
        vis     = i_drawing & ~i_trans & en_eff;
    end

    always_comb begin
        logic found;
        found     = 1'b0;
        colr_s1_d = bg_eff;
        for (int unsigned k = 0; k < LAYERS; k++) begin
            if (vis[k] && !found) begin
                colr_s1_d = i_rgb[k*CW +: CW];
                found     = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk_pix or negedge i_rst_n) begin
        if (!i_rst_n) begin
            en_sh_q   <= '1;
            bg_sh_q   <= BG_RESET;
            colr_s1_q <= '0;
            de_s1_q   <= 1'b0;
            hs_s1_q   <= !H_POL;
            vs_s1_q   <= !V_POL;
        end else begin
            en_sh_q   <= en_sh_d;
            bg_sh_q   <= bg_sh_d;
            colr_s1_q <= colr_s1_d;
            de_s1_q   <= i_de;
            hs_s1_q   <= i_hsync;
            vs_s1_q   <= i_vsync;
        end
    end

    always_ff @(posedge i_clk_pix or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vga_hsync   <= !H_POL;
            vga_vsync   <= !V_POL;
            vga_blank_n <= 1'b0;
            vga_r       <= '0;
            vga_g       <= '0;
            vga_b       <= '0;
        end else begin
            vga_hsync   <= hs_s1_q;
            vga_vsync   <= vs_s1_q;
            vga_blank_n <= de_s1_q;
            vga_r       <= de_s1_q ? colr_s1_q[CW-1 -: COLR_BITS]            : '0;
            vga_g       <= de_s1_q ? colr_s1_q[2*COLR_BITS-1 -: COLR_BITS]   : '0;
            vga_b       <= de_s1_q ? colr_s1_q[COLR_BITS-1:0]                : '0;
        end
    end

    assign vga_sync_n = 1'b1;

`ifdef SPRITE_LAYER_MIXER_COLLISION_EN
    logic [LAYERS-1:0] acc_q, acc_d;
    logic              multi;

    // Two or more set bits: clearing the lowest set bit leaves something behind.
    always_comb begin
        multi = |(vis & (vis - LAYERS'(1)));
        if (i_frame)
            acc_d = (i_de && multi) ? vis : '0;
        else if (i_de && multi)
            acc_d = acc_q | vis;
        else
            acc_d = acc_q;
    end

    always_ff @(posedge i_clk_pix or negedge i_rst_n) begin
        if (!i_rst_n) begin
            acc_q         <= '0;
            o_collide     <= '0;
            o_collide_stb <= 1'b0;
        end else begin
            acc_q         <= acc_d;
            o_collide_stb <= i_frame;
            if (i_frame)
                o_collide <= acc_q;
        end
    end
`endif

endmodule

// File: tb/tb_sprite_layer_mixer.sv
// Directed self-checking bench for sprite_layer_mixer (LAYERS=4, COLR_BITS=8).
module tb_sprite_layer_mixer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        frame, de, hsync, vsync;
    logic [3:0]  drawing, trans, layer_en;
    logic [95:0] rgb;
    logic [23:0] bg_colr;
    logic        vga_hsync, vga_vsync, vga_blank_n, vga_sync_n;
    logic [7:0]  vga_r, vga_g, vga_b;
`ifdef SPRITE_LAYER_MIXER_COLLISION_EN
    logic [3:0]  collide;
    logic        collide_stb;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sprite_layer_mixer #(
        .LAYERS(4), .COLR_BITS(8), .BG_RESET(24'h6BE9F2), .H_POL(1'b1), .V_POL(1'b1)
    ) dut (
        .i_clk_pix(clk), .i_rst_n(rst_n), .i_frame(frame), .i_de(de),
        .i_hsync(hsync), .i_vsync(vsync), .i_drawing(drawing), .i_trans(trans),
        .i_rgb(rgb), .i_layer_en(layer_en), .i_bg_colr(bg_colr),
`ifdef SPRITE_LAYER_MIXER_COLLISION_EN
        .o_collide(collide), .o_collide_stb(collide_stb),
`endif
        .vga_hsync(vga_hsync), .vga_vsync(vga_vsync), .vga_blank_n(vga_blank_n),
        .vga_sync_n(vga_sync_n), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [31:0] rgb_out();
        return {8'h00, vga_r, vga_g, vga_b};
    endfunction

    logic hs_h[24], vs_h[24], de_h[24];

    initial begin
        rst_n = 1'b0; frame = 1'b0; de = 1'b0; hsync = 1'b0; vsync = 1'b0;
        drawing = '0; trans = '0; layer_en = 4'hF; rgb = '0; bg_colr = 24'h6BE9F2;

        #12;
        chk("rst_hsync",  32'(vga_hsync),   32'h0);
        chk("rst_vsync",  32'(vga_vsync),   32'h0);
        chk("rst_blank",  32'(vga_blank_n), 32'h0);
        chk("rst_sync_n", 32'(vga_sync_n),  32'h1);
        chk("rst_rgb",    rgb_out(),        32'h0);
`ifdef SPRITE_LAYER_MIXER_COLLISION_EN
        chk("rst_collide", 32'(collide),     32'h0);
        chk("rst_stb",     32'(collide_stb), 32'h0);
`endif

        @(negedge clk);
        rst_n = 1'b1;
        de = 1'b1;
        tick(2);
        chk("bg_rgb",   rgb_out(),        32'h6BE9F2);
        chk("bg_blank", 32'(vga_blank_n), 32'h1);

        rgb[0 +: 24]  = 24'hFF0000;
        rgb[48 +: 24] = 24'h00FF00;
        drawing = 4'b0101;
        tick(2);
        chk("prio_l0", rgb_out(), 32'hFF0000);
        trans = 4'b0001;
        tick(2);
        chk("prio_l2", rgb_out(), 32'h00FF00);
        trans = 4'b0000;
        de = 1'b0;
        tick(2);
        chk("blank_rgb", rgb_out(),        32'h0);
        chk("blank_n",   32'(vga_blank_n), 32'h0);

        de = 1'b1;
        drawing = 4'b0001;
        bg_colr = 24'h123456;
        layer_en = 4'b1110;
        tick(2);
        chk("shadow_hold_l0", rgb_out(), 32'hFF0000);
        drawing = 4'b0000;
        tick(2);
        chk("shadow_hold_bg", rgb_out(), 32'h6BE9F2);
        drawing = 4'b0001;
        frame = 1'b1;
        tick(1);
        frame = 1'b0;
        tick(1);
        chk("frame_bypass", rgb_out(), 32'h123456);
        tick(1);
        chk("frame_held", rgb_out(), 32'h123456);

        for (int t = 0; t < 24; t++) begin
            if (t >= 2) begin
                chk("lat_hsync", 32'(vga_hsync),   32'(hs_h[t-2]));
                chk("lat_vsync", 32'(vga_vsync),   32'(vs_h[t-2]));
                chk("lat_blank", 32'(vga_blank_n), 32'(de_h[t-2]));
            end
            hs_h[t] = 1'($urandom_range(0, 1));
            vs_h[t] = 1'($urandom_range(0, 1));
            de_h[t] = 1'($urandom_range(0, 1));
            hsync = hs_h[t]; vsync = vs_h[t]; de = de_h[t];
            tick(1);
        end

        de = 1'b1; hsync = 1'b1; vsync = 1'b1;
        rgb[24 +: 24] = 24'h0000FF;
        drawing = 4'b0011;
        tick(2);
        chk("pre_reset_rgb",   rgb_out(),      32'h0000FF);
        chk("pre_reset_hsync", 32'(vga_hsync), 32'h1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rgb",   rgb_out(),        32'h0);
        chk("async_blank", 32'(vga_blank_n), 32'h0);
        chk("async_hsync", 32'(vga_hsync),   32'h0);
        chk("async_vsync", 32'(vga_vsync),   32'h0);
        #1 rst_n = 1'b1;
        tick(1);
        tick(2);
        chk("post_reset_en", rgb_out(), 32'hFF0000);
        drawing = 4'b0000;
        tick(2);
        chk("post_reset_bg", rgb_out(), 32'h6BE9F2);

`ifdef SPRITE_LAYER_MIXER_COLLISION_EN
        hsync = 1'b0; vsync = 1'b0;
        layer_en = 4'hF;
        frame = 1'b1;
        tick(1);
        frame = 1'b0;
        drawing = 4'b1010;
        tick(5);
        drawing = 4'b0000;
        tick(3);
        frame = 1'b1;
        tick(1);
        chk("coll_stb_hi",  32'(collide_stb), 32'h1);
        chk("coll_value",   32'(collide),     32'hA);
        frame = 1'b0;
        tick(1);
        chk("coll_stb_lo",  32'(collide_stb), 32'h0);
        chk("coll_hold",    32'(collide),     32'hA);
        tick(3);
        frame = 1'b1;
        tick(1);
        chk("coll_clear",   32'(collide),     32'h0);
        chk("coll_stb2",    32'(collide_stb), 32'h1);
        frame = 1'b0;
        tick(1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
